// File: rtl/clock_alarm_core_if.sv
// Control and display bundle for the alarm clock core.
// The master side drives the user controls; the slave side is the clock core.
interface clock_alarm_core_if;
  logic       tick_1hz;
  logic       time_set;
  logic       alarm_set;
  logic       minutes_up;
  logic       hours_up;
  logic       alarm_on;
  logic       alarm_reset;
  logic       debug;
  logic [5:0] seconds;
  logic [5:0] disp_minutes;
  logic [4:0] disp_hours;
  logic       alarm_ringing;
  logic       alarm_armed;

  modport master (
    output tick_1hz, time_set, alarm_set, minutes_up, hours_up, alarm_on, alarm_reset, debug,
    input  seconds, disp_minutes, disp_hours, alarm_ringing, alarm_armed
  );

  modport slave (
    input  tick_1hz, time_set, alarm_set, minutes_up, hours_up, alarm_on, alarm_reset, debug,
    output seconds, disp_minutes, disp_hours, alarm_ringing, alarm_armed
  );
endinterface

// File: rtl/clock_alarm_core.sv
// 24-hour time-of-day counter with settable alarm and a four-state alarm FSM.
module clock_alarm_core #(
  parameter int unsigned RING_SECONDS    = 60,
  parameter int unsigned ALARM_RST_HOURS = 7
) (
  input logic               clk,
  input logic               reset,
  clock_alarm_core_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StArmed, StRinging, StDone} state_e;

  localparam logic [7:0] RingLimit = 8'(RING_SECONDS);
  localparam logic [4:0] AlarmRstHours = 5'(ALARM_RST_HOURS);

  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hr_q, hr_d;
  logic [5:0] al_min_q, al_min_d;
  logic [4:0] al_hr_q, al_hr_d;
  logic       min_key_q, hr_key_q;
  logic [7:0] ring_cnt_q;
  logic       ringing_q, armed_q;
  state_e     state_q;

  logic min_edge, hr_edge, alarm_mode, count_tick, match_d, match_now;

  assign min_edge   = bus.minutes_up & ~min_key_q;
  assign hr_edge    = bus.hours_up & ~hr_key_q;
  assign alarm_mode = bus.alarm_set & ~bus.time_set;
  assign count_tick = bus.tick_1hz & ~bus.time_set;

  // Next time-of-day and alarm setting from ticks and key edges.
  always_comb begin
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    al_min_d = al_min_q;
    al_hr_d  = al_hr_q;
    if (bus.time_set) begin
      // Setting minutes never carries into hours.
      sec_d = '0;
      if (min_edge) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      if (hr_edge)  hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
    end else begin
      if (bus.tick_1hz) begin
        if (bus.debug || sec_q == 6'd59) begin
          sec_d = '0;
          min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          if (min_q == 6'd59) hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
      if (bus.alarm_set) begin
        if (min_edge) al_min_d = (al_min_q == 6'd59) ? 6'd0 : al_min_q + 6'd1;
        if (hr_edge)  al_hr_d  = (al_hr_q == 5'd23) ? 5'd0 : al_hr_q + 5'd1;
      end
    end
  end

  // Only a counting tick landing exactly on hh:mm:00 of the alarm may start ringing.
  assign match_d   = count_tick && (hr_d == al_hr_q) && (min_d == al_min_q) && (sec_d == 6'd0);
  assign match_now = (hr_q == al_hr_q) && (min_q == al_min_q);

  // Time, alarm setting and key-history registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      al_min_q  <= '0;
      al_hr_q   <= AlarmRstHours;
      min_key_q <= 1'b1;
      hr_key_q  <= 1'b1;
    end else begin
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      al_min_q  <= al_min_d;
      al_hr_q   <= al_hr_d;
      min_key_q <= bus.minutes_up;
      hr_key_q  <= bus.hours_up;
    end
  end

  // Alarm FSM with registered ringing/armed outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      ring_cnt_q <= '0;
      ringing_q  <= 1'b0;
      armed_q    <= 1'b0;
    end else if (!bus.alarm_on) begin
      state_q   <= StIdle;
      ringing_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StArmed;
          armed_q <= 1'b1;
        end
        StArmed: begin
          if (match_d) begin
            state_q    <= StRinging;
            ring_cnt_q <= '0;
            ringing_q  <= 1'b1;
          end
        end
        StRinging: begin
          if (bus.alarm_reset) begin
            state_q   <= StDone;
            ringing_q <= 1'b0;
            armed_q   <= 1'b0;
          end else if (bus.tick_1hz) begin
            ring_cnt_q <= ring_cnt_q + 8'd1;
            if (ring_cnt_q + 8'd1 == RingLimit) begin
              state_q   <= StDone;
              ringing_q <= 1'b0;
              armed_q   <= 1'b0;
            end
          end
        end
        StDone: begin
          // Stay done until the alarm minute has passed, so it cannot retrigger.
          if (!match_now) begin
            state_q <= StArmed;
            armed_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.seconds       = sec_q;
  assign bus.disp_minutes  = alarm_mode ? al_min_q : min_q;
  assign bus.disp_hours    = alarm_mode ? al_hr_q : hr_q;
  assign bus.alarm_ringing = ringing_q;
  assign bus.alarm_armed   = armed_q;

endmodule

// File: doc/clock_alarm_core.md
CLOCK_ALARM_CORE -- requirements
Module: clock_alarm_core

Interface
REQ-001 Parameter: RING_SECONDS, 60, number of 1 Hz ticks the alarm rings before self-clearing (1..255).
REQ-002 Parameter: ALARM_RST_HOURS, 7, alarm hours value loaded at reset (0..23).
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  reset is synchronous and active-low: reset==0 sampled at a clk rising edge resets the block.
REQ-005 tick_1hz  in  1  one-clk-wide pulse, once per second.
REQ-006 time_set  in  1  level; high = time-setting mode.
REQ-007 alarm_set  in  1  level; high = alarm-setting mode.
REQ-008 minutes_up  in  1  level, high while minutes key pressed.
REQ-009 hours_up  in  1  level, high while hours key pressed.
REQ-010 alarm_on  in  1  level; high = alarm enabled.
REQ-011 alarm_reset  in  1  level; high = acknowledge/silence alarm.
REQ-012 debug  in  1  level; high = fast mode, each tick advances one minute.
REQ-013 seconds  out  6  current seconds, binary 0..59.
REQ-014 disp_minutes  out  6  minutes to display, binary 0..59.
REQ-015 disp_hours  out  5  hours to display, binary 0..23.
REQ-016 alarm_ringing  out  1  high while alarm FSM is in RINGING.
REQ-017 alarm_armed  out  1  high while alarm FSM is in ARMED or RINGING.

Function
REQ-018 Button edges: minutes_up/hours_up registered once; an action occurs only on the cycle a 0->1 transition is seen (prev=0, cur=1); holding a key yields exactly one action.
REQ-019 Time counting (time_set=0, debug=0): on tick_1hz, seconds+1; 59->0 carries minutes+1; minutes 59->0 carries hours+1; hours 23->0; update visible the cycle after the tick edge.
REQ-020 Debug counting (time_set=0, debug=1): on tick_1hz, seconds forced to 0, minutes+1 with normal minute/hour carry.
REQ-021 Time setting (time_set=1): ticks ignored, seconds held at 0; minutes_up edge -> minutes+1 mod 60, no carry to hours; hours_up edge -> hours+1 mod 24.
REQ-022 Alarm setting (alarm_set=1, time_set=0): minutes_up edge -> alarm minutes+1 mod 60; hours_up edge -> alarm hours+1 mod 24; time keeps counting.
REQ-023 time_set and alarm_set both high: time_set has priority; alarm registers unchanged.
REQ-024 Key edges with neither set mode active are ignored.
REQ-025 Display mux: disp_hours/disp_minutes = alarm registers when alarm_set=1 and time_set=0, else current time; seconds output always current seconds.
REQ-026 Alarm FSM states: IDLE, ARMED, RINGING, DONE.
REQ-027 IDLE -> ARMED when alarm_on=1.
REQ-028 ARMED -> RINGING on the edge where a counting tick (REQ-019/020) produces hours==alarm hours, minutes==alarm minutes, seconds==0; alarm_ringing high from the same cycle the matching time is visible.
REQ-029 Time-setting or alarm-setting into a matching value never triggers RINGING.
REQ-030 RINGING: ring counter cleared on entry, +1 per tick_1hz; -> DONE when alarm_reset=1 or counter reaches RING_SECONDS; alarm_reset has priority over same-cycle tick.
REQ-031 DONE -> ARMED when current time no longer matches alarm hours/minutes (prevents retrigger in the same minute).
REQ-032 Any state -> IDLE when alarm_on=0; takes priority over all other transitions.
REQ-033 alarm_reset in IDLE, ARMED or DONE has no effect.

Reset
REQ-034 On reset: time 00:00:00, alarm minutes 0, alarm hours ALARM_RST_HOURS, FSM IDLE, ring counter 0, alarm_ringing=0, alarm_armed=0.
REQ-035 On reset the key edge registers load 1, so a key held through reset release generates no action.
REQ-036 reset mid-ringing silences alarm_ringing on the next cycle, regardless of alarm_on.

Verification
REQ-037 Time 23:59:59, time_set=0, debug=0, one tick -> 00:00:00 next cycle.
REQ-038 time_set=1, time 00:00:30, 3 minutes_up pulses and 25 hours_up pulses, ticks running -> 01:03:00, seconds stay 0.
REQ-039 alarm_on=1, alarm 07:00, time 06:59:59, tick -> alarm_ringing=1 with time 07:00:00; 60 further ticks without alarm_reset -> alarm_ringing=0, FSM DONE; after time reaches 07:01 -> alarm_armed remains 1, no retrigger.
REQ-040 Ringing, alarm_reset=1 coincident with tick -> alarm_ringing=0 next cycle, FSM DONE; alarm_on=0 -> alarm_armed=0.
REQ-041 debug=1, time 06:58:40, two ticks -> 07:00:00 and alarm fires if armed; minutes_up held high 100 cycles in alarm_set -> alarm minutes increments by exactly 1.
REQ-042 time_set=1 and alarm_set=1 with hours_up pulse -> time hours+1, alarm hours unchanged, display shows time.
